// File: rtl/alu_seq.sv
// Sequential accumulator ALU: single-cycle ops plus bit-serial SHRN/CSLN (and MUL when
// ALU_SEQ_MUL_EN is defined); registered result and flags with a one-cycle done pulse.
module alu_seq #(
    parameter int W  = 16,
    parameter int CW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] in_acc,
    input  logic [W-1:0] in_mem,
    output logic [W-1:0] z,
    output logic         cond,
    output logic         carry,
    output logic         zero,
    output logic         err,
    output logic         busy,
    output logic         done
);

    // Counter must hold either a shift count (CW bits) or W (up to 32) for MUL.
    localparam int NW = (CW > 6) ? CW : 6;

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_next;

    logic [3:0]    op_r;
    logic [W-1:0]  work;
    logic [NW-1:0] cnt;
    logic [CW-1:0] n_in;
`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]  mcand;
    logic [W-1:0]  hi;
    logic [W:0]    hi_sum;
`endif

    logic          fin, fin_ill, wr_z, wr_cond, load;
    logic          new_carry, new_cond;
    logic [W-1:0]  new_z, step;

    assign n_in = in_mem[CW-1:0];
    assign busy = (state == EXEC);

    function automatic logic [W-1:0] asr1(input logic [W-1:0] x);
        return {x[W-1], x[W-1:1]};
    endfunction

    function automatic logic [W-1:0] rol1(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        fin        = 1'b0;
        fin_ill    = 1'b0;
        wr_z       = 1'b0;
        wr_cond    = 1'b0;
        load       = 1'b0;
        new_z      = z;
        new_cond   = cond;
        new_carry  = 1'b0;
        step       = work;
`ifdef ALU_SEQ_MUL_EN
        hi_sum     = '0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        4'd0:  begin fin = 1'b1; wr_z = 1'b1; new_z = '0; end
                        4'd1:  begin fin = 1'b1; wr_z = 1'b1; new_z = ~in_acc; end
                        4'd2:  begin fin = 1'b1; wr_z = 1'b1; new_z = asr1(in_acc); end
                        4'd3:  begin fin = 1'b1; wr_z = 1'b1; new_z = rol1(in_acc); end
                        4'd5:  begin
                            fin  = 1'b1;
                            wr_z = 1'b1;
                            {new_carry, new_z} = {1'b0, in_acc} + {1'b0, in_mem};
                        end
                        4'd6:  begin fin = 1'b1; wr_z = 1'b1; new_z = in_acc; end
                        4'd7:  begin fin = 1'b1; wr_z = 1'b1; new_z = in_mem; end
                        4'd9:  begin fin = 1'b1; wr_cond = 1'b1; new_cond = in_acc[W-1]; end
                        4'd10, 4'd11: begin
                            // A zero count degenerates to a plain load of the accumulator.
                            if (n_in == '0) begin
                                fin   = 1'b1;
                                wr_z  = 1'b1;
                                new_z = in_acc;
                            end else begin
                                load       = 1'b1;
                                state_next = EXEC;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        4'd12: begin load = 1'b1; state_next = EXEC; end
`endif
                        default: fin_ill = 1'b1;
                    endcase
                end
            end
            EXEC: begin
                case (op_r)
                    4'd10: step = asr1(work);
                    4'd11: step = rol1(work);
`ifdef ALU_SEQ_MUL_EN
                    // Shift-add: {hi, work} holds partial product high half and the
                    // not-yet-consumed multiplier bits in the low half.
                    4'd12: begin
                        hi_sum    = {1'b0, hi} + (work[0] ? {1'b0, mcand} : '0);
                        step      = {hi_sum[0], work[W-1:1]};
                        new_carry = |hi_sum[W:1];
                    end
`endif
                    default: step = work;
                endcase
                if (cnt == NW'(1)) begin
                    state_next = IDLE;
                    fin        = 1'b1;
                    wr_z       = 1'b1;
                    new_z      = step;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z     <= '0;
            cond  <= 1'b0;
            carry <= 1'b0;
            zero  <= 1'b1;
            err   <= 1'b0;
            done  <= 1'b0;
            op_r  <= '0;
            work  <= '0;
            cnt   <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand <= '0;
            hi    <= '0;
`endif
        end else begin
            done <= fin | fin_ill;
            if (load) begin
                op_r <= op;
                work <= in_acc;
                cnt  <= NW'(n_in);
`ifdef ALU_SEQ_MUL_EN
                mcand <= in_acc;
                hi    <= '0;
                if (op == 4'd12) begin
                    work <= in_mem;
                    cnt  <= NW'(W);
                end
`endif
            end else if (state == EXEC) begin
                work <= step;
                cnt  <= cnt - NW'(1);
`ifdef ALU_SEQ_MUL_EN
                hi   <= hi_sum[W:1];
`endif
            end
            if (fin) begin
                if (wr_z) begin
                    z    <= new_z;
                    zero <= (new_z == '0);
                end
                if (wr_cond) cond <= new_cond;
                carry <= new_carry;
                err   <= 1'b0;
            end
            if (fin_ill) err <= 1'b1;
        end
    end

endmodule
